// File: rtl/iob_arbiter_pkg.sv
// Shared definitions for the IOb round-robin arbiter: FSM encoding and the
// read data returned when the watchdog aborts a transaction.
package iob_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Widest data bus supported; the arbiter slices off DATA_W bits.
  localparam int unsigned MAX_DATA_W = 256;
  localparam logic [MAX_DATA_W-1:0] TIMEOUT_RDATA = '1;

endpackage

// File: rtl/iob_rr_picker.sv
// Combinational round-robin selector: first set request bit at or above ptr,
// wrapping around N_PORTS.
module iob_rr_picker #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned IDX_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               any_o
);

  logic             found_c;
  logic [IDX_W:0]   idx_c;

  // ptr + i never exceeds 2*N_PORTS-2, so one conditional subtract wraps it.
  always_comb begin
    grant_o = '0;
    found_c = 1'b0;
    idx_c   = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      idx_c = (IDX_W+1)'(ptr_i) + (IDX_W+1)'(i);
      if (idx_c >= (IDX_W+1)'(N_PORTS)) begin
        idx_c = idx_c - (IDX_W+1)'(N_PORTS);
      end
      if (!found_c && req_i[idx_c[IDX_W-1:0]]) begin
        grant_o = idx_c[IDX_W-1:0];
        found_c = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/iob_arbiter.sv
// Round-robin arbiter sharing one downstream IOb port between N_PORTS
// single-pulse requesters, with an optional response watchdog.
module iob_arbiter
  import iob_arbiter_pkg::*;
#(
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [N_PORTS-1:0]            s_valid_i,
  input  logic [N_PORTS*ADDR_W-1:0]     s_address_i,
  input  logic [N_PORTS*DATA_W-1:0]     s_wdata_i,
  input  logic [N_PORTS*(DATA_W/8)-1:0] s_wstrb_i,
  output logic [DATA_W-1:0]             s_rdata_o,
  output logic [N_PORTS-1:0]            s_ready_o,
  output logic                          m_valid_o,
  output logic [ADDR_W-1:0]             m_address_o,
  output logic [DATA_W-1:0]             m_wdata_o,
  output logic [DATA_W/8-1:0]           m_wstrb_o,
  input  logic [DATA_W-1:0]             m_rdata_i,
  input  logic                          m_ready_i,
  output logic                          timeout_o
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned IDX_W   = $clog2(N_PORTS);
  localparam int unsigned CNT_W   = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
  localparam bit          WDOG_EN = (TIMEOUT_W > 0);
  // Abort fires on the edge at which the counter would reach 2^W-1.
  localparam logic [CNT_W-1:0] CNT_LAST = ~CNT_W'(1);
  localparam logic [DATA_W-1:0] ABORT_RDATA = TIMEOUT_RDATA[DATA_W-1:0];

  // Per-port request buffer
  logic [N_PORTS-1:0] pend_q, pend_d;
  logic [N_PORTS-1:0] accept_c, clr_c;
  logic [ADDR_W-1:0]  addr_q  [N_PORTS];
  logic [DATA_W-1:0]  wdata_q [N_PORTS];
  logic [STRB_W-1:0]  wstrb_q [N_PORTS];

  // Arbitration and transaction state
  state_e             state_q;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               m_valid_q;
  logic [ADDR_W-1:0]  m_addr_q;
  logic [DATA_W-1:0]  m_wdata_q;
  logic [STRB_W-1:0]  m_wstrb_q;
  logic [N_PORTS-1:0] s_ready_q;
  logic [DATA_W-1:0]  s_rdata_q;
  logic               timeout_q;

  logic [IDX_W-1:0]   pick_c;
  logic               any_c;
  logic [N_PORTS-1:0] grant_oh_c;
  logic               done_c;
  logic               expire_c;
  logic [IDX_W-1:0]   ptr_nxt_c;

  iob_rr_picker #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i   (pend_q),
    .ptr_i   (ptr_q),
    .grant_o (pick_c),
    .any_o   (any_c)
  );

  assign accept_c   = s_valid_i & ~pend_q;
  assign grant_oh_c = N_PORTS'(1) << grant_q;
  assign done_c     = (state_q == ST_WAIT) && m_ready_i;
  assign expire_c   = WDOG_EN && (state_q == ST_WAIT) && !m_ready_i && (cnt_q == CNT_LAST);
  assign clr_c      = (done_c || expire_c) ? grant_oh_c : '0;
  assign pend_d     = (pend_q & ~clr_c) | accept_c;
  assign ptr_nxt_c  = (grant_q == IDX_W'(N_PORTS - 1)) ? '0 : grant_q + IDX_W'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Fields are latched only on acceptance; a repeat valid leaves them intact.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int unsigned k = 0; k < N_PORTS; k++) begin
        addr_q[k]  <= '0;
        wdata_q[k] <= '0;
        wstrb_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N_PORTS; k++) begin
        if (accept_c[k]) begin
          addr_q[k]  <= s_address_i[k*ADDR_W +: ADDR_W];
          wdata_q[k] <= s_wdata_i[k*DATA_W +: DATA_W];
          wstrb_q[k] <= s_wstrb_i[k*STRB_W +: STRB_W];
        end
      end
    end
  end

  // Transaction FSM; pulses default low every cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      s_ready_q <= '0;
      s_rdata_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      m_valid_q <= 1'b0;
      s_ready_q <= '0;
      s_rdata_q <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_c) begin
            grant_q   <= pick_c;
            m_addr_q  <= addr_q[pick_c];
            m_wdata_q <= wdata_q[pick_c];
            m_wstrb_q <= wstrb_q[pick_c];
            m_valid_q <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_c) begin
            s_ready_q <= grant_oh_c;
            s_rdata_q <= m_rdata_i;
            ptr_q     <= ptr_nxt_c;
            state_q   <= ST_IDLE;
          end else if (expire_c) begin
            s_ready_q <= grant_oh_c;
            s_rdata_q <= ABORT_RDATA;
            timeout_q <= 1'b1;
            ptr_q     <= ptr_nxt_c;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_valid_o   = m_valid_q;
  assign m_address_o = m_addr_q;
  assign m_wdata_o   = m_wdata_q;
  assign m_wstrb_o   = m_wstrb_q;
  assign s_ready_o   = s_ready_q;
  assign s_rdata_o   = s_rdata_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_iob_arbiter.sv
// Self-checking bench for iob_arbiter: directed scenarios plus a randomized
// run against a transaction-level round-robin model.
module tb_iob_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  s_valid, wd_valid;
  logic [63:0] s_addr, s_wdata;
  logic [7:0]  s_wstrb;
  logic [31:0] s_rdata, wd_srdata;
  logic [1:0]  s_ready, wd_sready;
  logic        m_valid, wd_mvalid;
  logic [31:0] m_addr, m_wdata, wd_maddr, wd_mwdata;
  logic [3:0]  m_wstrb, wd_mwstrb;
  logic [31:0] m_rdata, wd_mrdata;
  logic        m_ready, wd_mready;
  logic        tmo, wd_tmo;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        got;
    logic [7:0]  wait_cyc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic [3:0]  h_strb;
    logic [1:0]  sready;
    logic [31:0] srdata;
    logic        tmo;
  } obs_t;

  always #5 clk = ~clk;

  iob_arbiter #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(s_valid), .s_address_i(s_addr),
    .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_rdata_o(s_rdata), .s_ready_o(s_ready),
    .m_valid_o(m_valid), .m_address_o(m_addr), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
    .m_rdata_i(m_rdata), .m_ready_i(m_ready), .timeout_o(tmo));

  iob_arbiter #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_W(4)) dut_wd (
    .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(wd_valid), .s_address_i(s_addr),
    .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_rdata_o(wd_srdata), .s_ready_o(wd_sready),
    .m_valid_o(wd_mvalid), .m_address_o(wd_maddr), .m_wdata_o(wd_mwdata), .m_wstrb_o(wd_mwstrb),
    .m_rdata_i(wd_mrdata), .m_ready_i(wd_mready), .timeout_o(wd_tmo));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int k, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    s_addr[k*32 +: 32]  = a;
    s_wdata[k*32 +: 32] = w;
    s_wstrb[k*4 +: 4]   = s;
  endtask

  task automatic pulse(input logic [1:0] mask);
    s_valid = mask;
    tick();
    s_valid = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Waits for a downstream request, answers it after lat WAIT cycles, and
  // reports what the DUT showed along the way.
  task automatic serve(input int lat, input logic [31:0] rd, output obs_t o);
    o = '0;
    for (int i = 0; i < 20 && !o.got; i++) begin
      if (m_valid) begin
        o.got = 1'b1; o.wait_cyc = 8'(i);
        o.addr = m_addr; o.wdata = m_wdata; o.strb = m_wstrb;
      end else begin
        tick();
      end
    end
    if (!o.got) return;
    for (int i = 0; i < lat; i++) tick();
    o.h_addr = m_addr; o.h_wdata = m_wdata; o.h_strb = m_wstrb;
    m_ready = 1'b1; m_rdata = rd;
    tick();
    m_ready = 1'b0; m_rdata = '0;
    o.sready = s_ready; o.srdata = s_rdata; o.tmo = tmo;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_ready = 1'b1; wd_mready = 1'b1; m_rdata = 32'h1234_5678;
    tick();
    tick();
    n_checks++;
    if ({s_ready, s_rdata, m_valid, m_addr, m_wdata, m_wstrb, tmo} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got ready=%b rdata=%h mvalid=%b addr=%h expected all zero", s_ready, s_rdata, m_valid, m_addr);
    end
    n_checks++;
    if ({wd_sready, wd_srdata, wd_mvalid, wd_maddr, wd_mwdata, wd_mwstrb, wd_tmo} !== '0) begin
      n_fail++; $display("FAIL reset_outputs_wd: got ready=%b rdata=%h mvalid=%b expected all zero", wd_sready, wd_srdata, wd_mvalid);
    end
    rst_n = 1'b1;
    tick();
    m_ready = 1'b0; wd_mready = 1'b0; m_rdata = '0;
    tick();
    n_checks++;
    if ({s_ready, m_valid, tmo, wd_sready, wd_mvalid} !== '0) begin
      n_fail++; $display("FAIL reset_stray_ready: got ready=%b mvalid=%b expected 0", s_ready, m_valid);
    end
  endtask

  task automatic test_single_read();
    obs_t o;
    set_port(0, 32'h100, 32'h0, 4'h0);
    pulse(2'b01);
    serve(1, 32'hCAFE_F00D, o);
    n_checks++;
    if ({o.got, o.wait_cyc, o.addr, o.strb} !== {1'b1, 8'd1, 32'h100, 4'h0}) begin
      n_fail++; $display("FAIL single_issue: got valid=%b wait=%0d addr=%h strb=%h expected 1 1 00000100 0", o.got, o.wait_cyc, o.addr, o.strb);
    end
    n_checks++;
    if ({o.sready, o.srdata, o.tmo} !== {2'b01, 32'hCAFE_F00D, 1'b0}) begin
      n_fail++; $display("FAIL single_resp: got ready=%b rdata=%h tmo=%b expected 01 cafef00d 0", o.sready, o.srdata, o.tmo);
    end
    tick();
    n_checks++;
    if ({s_ready, s_rdata} !== '0) begin
      n_fail++; $display("FAIL single_pulse_end: got ready=%b rdata=%h expected 0 0", s_ready, s_rdata);
    end
  endtask

  task automatic test_write();
    obs_t o;
    set_port(1, 32'h40, 32'h1234_5678, 4'b0011);
    pulse(2'b10);
    set_port(1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 4'b1111);
    serve(3, 32'h0, o);
    n_checks++;
    if ({o.got, o.wait_cyc, o.addr, o.wdata, o.strb} !== {1'b1, 8'd1, 32'h40, 32'h1234_5678, 4'b0011}) begin
      n_fail++; $display("FAIL write_issue: got addr=%h wdata=%h strb=%b wait=%0d expected 00000040 12345678 0011 1", o.addr, o.wdata, o.strb, o.wait_cyc);
    end
    n_checks++;
    if ({o.h_addr, o.h_wdata, o.h_strb} !== {32'h40, 32'h1234_5678, 4'b0011}) begin
      n_fail++; $display("FAIL write_hold: got addr=%h wdata=%h strb=%b expected 00000040 12345678 0011", o.h_addr, o.h_wdata, o.h_strb);
    end
    n_checks++;
    if (o.sready !== 2'b10) begin
      n_fail++; $display("FAIL write_resp: got ready=%b expected 10", o.sready);
    end
  endtask

  task automatic test_simultaneous();
    obs_t o;
    logic [31:0] exp_a [4];
    logic [1:0]  exp_r [4];
    exp_a = '{32'h10, 32'h20, 32'h10, 32'h20};
    exp_r = '{2'b01, 2'b10, 2'b01, 2'b10};
    set_port(0, 32'h10, 32'h0, 4'h0);
    set_port(1, 32'h20, 32'h0, 4'h0);
    for (int n = 0; n < 4; n++) begin
      if (n == 0 || n == 2) pulse(2'b11);
      serve(2, 32'hAAAA_0000 + 32'(n), o);
      n_checks++;
      if ({o.got, o.wait_cyc, o.addr, o.sready, o.srdata} !== {1'b1, 8'd1, exp_a[n], exp_r[n], 32'hAAAA_0000 + 32'(n)}) begin
        n_fail++; $display("FAIL simul_%0d: got addr=%h ready=%b rdata=%h wait=%0d expected %h %b %h 1", n, o.addr, o.sready, o.srdata, o.wait_cyc, exp_a[n], exp_r[n], 32'hAAAA_0000 + 32'(n));
      end
    end
  endtask

  task automatic test_fairness();
    obs_t o;
    int p;
    logic [31:0] rd;
    set_port(0, 32'h1000, 32'h0, 4'h0);
    set_port(1, 32'h2000, 32'h0, 4'h0);
    pulse(2'b11);
    for (int n = 0; n < 5; n++) begin
      p = n % 2;
      rd = $urandom;
      serve(1 + n % 3, rd, o);
      n_checks++;
      if ({o.got, o.addr, o.sready, o.srdata} !== {1'b1, 32'h1000 * 32'(p + 1), 2'(1 << p), rd}) begin
        n_fail++; $display("FAIL fair_grant_%0d: got addr=%h ready=%b rdata=%h expected port %0d rdata %h", n, o.addr, o.sready, o.srdata, p, rd);
      end
      if (n < 3) pulse(2'(1 << p));
    end
  endtask

  task automatic test_watchdog();
    logic found, late;
    int v_wait, k;
    logic [67:0] fields;
    set_port(0, 32'h300, 32'h0, 4'h0);
    wd_valid = 2'b01; tick(); wd_valid = '0;
    found = 1'b0; v_wait = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (wd_mvalid) found = 1'b1;
      else begin tick(); v_wait++; end
    end
    n_checks++;
    if ({found, v_wait} !== {1'b1, 32'sd1}) begin
      n_fail++; $display("FAIL wd_issue: got found=%b wait=%0d expected 1 1", found, v_wait);
    end
    found = 1'b0; k = 0; fields = '0;
    for (int i = 1; i <= 40 && !found; i++) begin
      tick();
      if (i == 1) fields = {wd_maddr, wd_mwdata, wd_mwstrb};
      if (wd_sready != 2'b00) begin found = 1'b1; k = i; end
    end
    n_checks++;
    if (k !== 16) begin
      n_fail++; $display("FAIL wd_latency: got %0d cycles after issue expected 16", k);
    end
    n_checks++;
    if ({wd_sready, wd_tmo, wd_srdata} !== {2'b01, 1'b1, 32'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL wd_abort: got ready=%b tmo=%b rdata=%h expected 01 1 ffffffff", wd_sready, wd_tmo, wd_srdata);
    end
    n_checks++;
    if (fields !== {32'h300, 32'h0, 4'h0}) begin
      n_fail++; $display("FAIL wd_fields: got %h expected %h", fields, {32'h300, 32'h0, 4'h0});
    end
    tick();
    n_checks++;
    if ({wd_sready, wd_tmo, wd_srdata} !== '0) begin
      n_fail++; $display("FAIL wd_pulse_end: got ready=%b tmo=%b rdata=%h expected 0", wd_sready, wd_tmo, wd_srdata);
    end
    wd_mready = 1'b1; wd_mrdata = 32'h5555_5555; tick(); wd_mready = 1'b0; wd_mrdata = '0;
    late = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wd_sready != 2'b00 || wd_tmo || wd_mvalid) late = 1'b1;
    end
    n_checks++;
    if (late !== 1'b0) begin
      n_fail++; $display("FAIL wd_late_ready: got response activity=%b expected 0", late);
    end
    // Ready in the very cycle the watchdog would expire.
    set_port(1, 32'h304, 32'h0, 4'h0);
    wd_valid = 2'b10; tick(); wd_valid = '0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (wd_mvalid) found = 1'b1;
      else tick();
    end
    for (int i = 0; i < 15; i++) tick();
    wd_mready = 1'b1; wd_mrdata = 32'hA5A5_5A5A; tick(); wd_mready = 1'b0; wd_mrdata = '0;
    n_checks++;
    if ({found, wd_sready, wd_tmo, wd_srdata} !== {1'b1, 2'b10, 1'b0, 32'hA5A5_5A5A}) begin
      n_fail++; $display("FAIL wd_ready_wins: got issued=%b ready=%b tmo=%b rdata=%h expected 1 10 0 a5a55a5a", found, wd_sready, wd_tmo, wd_srdata);
    end
  endtask

  task automatic test_reset_in_wait();
    obs_t o;
    logic found, act;
    set_port(0, 32'h500, 32'h0, 4'h0);
    pulse(2'b01);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_valid) found = 1'b1;
      else tick();
    end
    tick();
    rst_n = 1'b0; tick();
    n_checks++;
    if ({found, m_valid, s_ready, tmo} !== {1'b1, 1'b0, 2'b00, 1'b0}) begin
      n_fail++; $display("FAIL rstwait_reset: got issued=%b mvalid=%b ready=%b expected 1 0 00", found, m_valid, s_ready);
    end
    rst_n = 1'b1; m_ready = 1'b1; m_rdata = 32'hDEAD_0001;
    tick();
    m_ready = 1'b0; m_rdata = '0;
    act = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (s_ready != 2'b00 || m_valid || tmo) act = 1'b1;
    end
    n_checks++;
    if (act !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_quiet: got activity=%b expected 0", act);
    end
    set_port(1, 32'h600, 32'h0, 4'h0);
    pulse(2'b10);
    serve(2, 32'h1111_2222, o);
    n_checks++;
    if ({o.got, o.wait_cyc, o.addr, o.sready, o.srdata} !== {1'b1, 8'd1, 32'h600, 2'b10, 32'h1111_2222}) begin
      n_fail++; $display("FAIL rstwait_port1: got addr=%h ready=%b rdata=%h wait=%0d expected 00000600 10 11112222 1", o.addr, o.sready, o.srdata, o.wait_cyc);
    end
  endtask

  // Random requests and response latencies against a transaction-level model.
  task automatic test_random();
    logic [1:0]  mp, snap_mask, vld, exp_sr_v;
    logic [31:0] ma [2];
    logic [31:0] mw [2];
    logic [3:0]  ms [2];
    logic [31:0] exp_rd, exp_rd_v, a, w;
    logic [3:0]  s;
    logic        busy, exp_sr, exp_mv, exp_mv_n, issued_now;
    int          mptr, snap_ptr, cur, lat_left, exp_p;
    int          grants [2];
    apply_reset();
    mp = '0; busy = 1'b0; exp_sr = 1'b0; exp_mv = 1'b0; mptr = 0; cur = 0;
    snap_mask = '0; snap_ptr = 0; lat_left = 0; exp_rd = '0; grants = '{0, 0};
    for (int c = 0; c < 400; c++) begin
      tick();
      exp_sr_v = exp_sr ? 2'(1 << cur) : 2'b00;
      exp_rd_v = exp_sr ? exp_rd : 32'h0;
      n_checks++;
      if ({s_ready, s_rdata} !== {exp_sr_v, exp_rd_v}) begin
        n_fail++; $display("FAIL rand_resp c=%0d: got ready=%b rdata=%h expected %b %h", c, s_ready, s_rdata, exp_sr_v, exp_rd_v);
      end
      if (exp_sr) begin
        busy = 1'b0; mp[cur] = 1'b0; mptr = (cur + 1) % 2;
      end
      exp_sr = 1'b0;
      n_checks++;
      if (m_valid !== exp_mv) begin
        n_fail++; $display("FAIL rand_mvalid c=%0d: got %b expected %b", c, m_valid, exp_mv);
      end
      issued_now = 1'b0;
      if (m_valid && exp_mv) begin
        exp_p = snap_mask[snap_ptr] ? snap_ptr : 1 - snap_ptr;
        n_checks++;
        if ({m_addr, m_wdata, m_wstrb} !== {ma[exp_p], mw[exp_p], ms[exp_p]}) begin
          n_fail++; $display("FAIL rand_issue c=%0d: got %h/%h/%h expected port %0d %h/%h/%h", c, m_addr, m_wdata, m_wstrb, exp_p, ma[exp_p], mw[exp_p], ms[exp_p]);
        end
        busy = 1'b1; cur = exp_p; lat_left = $urandom_range(1, 6); grants[exp_p]++; issued_now = 1'b1;
      end else if (busy) begin
        n_checks++;
        if ({m_addr, m_wdata, m_wstrb} !== {ma[cur], mw[cur], ms[cur]}) begin
          n_fail++; $display("FAIL rand_hold c=%0d: got %h/%h/%h expected %h/%h/%h", c, m_addr, m_wdata, m_wstrb, ma[cur], mw[cur], ms[cur]);
        end
      end
      n_checks++;
      if (tmo !== 1'b0) begin
        n_fail++; $display("FAIL rand_timeout c=%0d: got %b expected 0", c, tmo);
      end
      exp_mv_n = !busy && (mp != 2'b00);
      snap_mask = mp; snap_ptr = mptr;
      for (int k = 0; k < 2; k++) begin
        vld[k] = ($urandom_range(0, 2) == 0);
        a = $urandom; w = $urandom; s = 4'($urandom);
        set_port(k, a, w, s);
        if (vld[k] && !mp[k]) begin
          mp[k] = 1'b1; ma[k] = a; mw[k] = w; ms[k] = s;
        end
      end
      s_valid = vld;
      m_ready = 1'b0; m_rdata = $urandom;
      if (busy && !issued_now) begin
        lat_left--;
        if (lat_left == 0) begin
          m_ready = 1'b1; exp_sr = 1'b1; exp_rd = m_rdata;
        end
      end else if ($urandom_range(0, 5) == 0) begin
        m_ready = 1'b1;
      end
      exp_mv = exp_mv_n;
    end
    s_valid = '0; m_ready = 1'b0; m_rdata = '0;
    n_checks++;
    if ((grants[0] > 0 && grants[1] > 0) !== 1'b1) begin
      n_fail++; $display("FAIL rand_coverage: got grants %0d/%0d expected both nonzero", grants[0], grants[1]);
    end
  endtask

  initial begin
    rst_n = 1'b0; s_valid = '0; wd_valid = '0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
    m_rdata = '0; m_ready = 1'b0; wd_mrdata = '0; wd_mready = 1'b0;
    test_reset();
    test_single_read();
    test_write();
    test_simultaneous();
    test_fairness();
    test_watchdog();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish within 1 ms");
    $fatal(1);
  end

endmodule
